// File: rtl/voice_allocator.sv
// voice_allocator
// Allocates the synthesizer's time-multiplexed voice slots to note events.
// Each accepted event is followed by a sequential scan of the voice table,
// one slot per cycle. A single apply cycle then updates the per-voice
// frequency, volume and active outputs.
// Optional build macro: VOICE_STEAL_EN.
//   Defined:   a note-on that finds no matching or free slot steals the oldest
//              active slot.
//   Undefined: such a note-on is discarded and note_dropped pulses for one
//              cycle.
module voice_allocator #(
    parameter int N_VOICES  = 8,
    parameter int NOTE_W    = 7,
    parameter int FREQ_W    = 32,
    parameter int VOL_SHIFT = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic                note_on,
    input  logic [NOTE_W-1:0]   note_num,
    input  logic [NOTE_W-1:0]   note_velocity,
    input  logic [FREQ_W-1:0]   note_frequency,
    output logic [FREQ_W-1:0]   frequencies   [N_VOICES],
    output logic [31:0]         voice_volumes [N_VOICES],
    output logic [N_VOICES-1:0] voice_active,
    output logic                note_dropped
);

    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Volume word: zero-extended velocity placed at the mixer's volume scale.
    function automatic logic [31:0] vol_of(input logic [NOTE_W-1:0] vel);
        vol_of = 32'(vel) << VOL_SHIFT;
    endfunction

    // Age counter increment that holds at its maximum instead of wrapping.
    function automatic logic [7:0] age_inc(input logic [7:0] age);
        age_inc = (age == 8'd255) ? age : (age + 8'd1);
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  accept_s;
    logic                  ready_r;
    logic                  dropped_r;
    logic [IDX_W-1:0]      idx_r;

    logic                  ev_on_r;
    logic [NOTE_W-1:0]     ev_note_r;
    logic [NOTE_W-1:0]     ev_vel_r;
    logic [FREQ_W-1:0]     ev_freq_r;

    logic                  match_found_r;
    logic [IDX_W-1:0]      match_idx_r;
    logic                  free_found_r;
    logic [IDX_W-1:0]      free_idx_r;

    logic [NOTE_W-1:0]     note_r [N_VOICES];
    logic [7:0]            age_r  [N_VOICES];
    logic [FREQ_W-1:0]     freq_r [N_VOICES];
    logic [31:0]           vol_r  [N_VOICES];
    logic [N_VOICES-1:0]   active_r;

    logic                  slot_active_s;
    logic [NOTE_W-1:0]     slot_note_s;
    logic                  hit_match_s;
    logic                  hit_free_s;

    logic                  alloc_s;
    logic [IDX_W-1:0]      alloc_idx_s;
    logic                  release_s;
    logic [IDX_W-1:0]      release_idx_s;
    logic                  drop_s;

    // Next-state logic for the IDLE -> SCAN -> APPLY -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (note_valid && ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_APPLY;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_APPLY: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered handshake ready and drop pulse; ready is low throughout reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_r   <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            ready_r   <= (state_nxt_s == ST_IDLE);
            dropped_r <= drop_s;
        end
    end

    // Event capture; a note-on with zero velocity is folded into a note-off here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ev_on_r   <= 1'b0;
            ev_note_r <= {NOTE_W{1'b0}};
            ev_vel_r  <= {NOTE_W{1'b0}};
            ev_freq_r <= {FREQ_W{1'b0}};
        end else if (accept_s) begin
            ev_on_r   <= note_on && (note_velocity != {NOTE_W{1'b0}});
            ev_note_r <= note_num;
            ev_vel_r  <= note_velocity;
            ev_freq_r <= note_frequency;
        end
    end

    // Comparisons for the slot currently addressed by the scan index.
    always_comb begin
        slot_active_s = active_r[idx_r];
        slot_note_s   = note_r[idx_r];
        hit_match_s   = slot_active_s && (slot_note_s == ev_note_r) && !match_found_r;
        hit_free_s    = !slot_active_s && !free_found_r;
    end

    // Scan index plus first-match and first-free trackers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_r         <= {IDX_W{1'b0}};
            match_found_r <= 1'b0;
            match_idx_r   <= {IDX_W{1'b0}};
            free_found_r  <= 1'b0;
            free_idx_r    <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            idx_r         <= {IDX_W{1'b0}};
            match_found_r <= 1'b0;
            match_idx_r   <= {IDX_W{1'b0}};
            free_found_r  <= 1'b0;
            free_idx_r    <= {IDX_W{1'b0}};
        end else if (state_r == ST_SCAN) begin
            idx_r <= idx_r + IDX_W'(1);
            if (hit_match_s) begin
                match_found_r <= 1'b1;
                match_idx_r   <= idx_r;
            end
            if (hit_free_s) begin
                free_found_r <= 1'b1;
                free_idx_r   <= idx_r;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic             old_found_r;
    logic [IDX_W-1:0] old_idx_r;
    logic [7:0]       old_age_r;
    logic [7:0]       slot_age_s;
    logic             hit_old_s;

    // Oldest candidate: only a strictly greater age replaces, so ties keep the lowest index.
    always_comb begin
        slot_age_s = age_r[idx_r];
        hit_old_s  = slot_active_s && (!old_found_r || (slot_age_s > old_age_r));
    end

    // Oldest-active-slot tracker, cleared on accept and refined across the scan.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            old_found_r <= 1'b0;
            old_idx_r   <= {IDX_W{1'b0}};
            old_age_r   <= 8'd0;
        end else if (accept_s) begin
            old_found_r <= 1'b0;
            old_idx_r   <= {IDX_W{1'b0}};
            old_age_r   <= 8'd0;
        end else if ((state_r == ST_SCAN) && hit_old_s) begin
            old_found_r <= 1'b1;
            old_idx_r   <= idx_r;
            old_age_r   <= slot_age_s;
        end
    end
`endif

    // Apply decision: match first, then a free slot, then steal or drop.
    always_comb begin
        alloc_s       = 1'b0;
        alloc_idx_s   = {IDX_W{1'b0}};
        release_s     = 1'b0;
        release_idx_s = {IDX_W{1'b0}};
        drop_s        = 1'b0;
        if (state_r == ST_APPLY) begin
            if (ev_on_r) begin
                if (match_found_r) begin
                    alloc_s     = 1'b1;
                    alloc_idx_s = match_idx_r;
                end else if (free_found_r) begin
                    alloc_s     = 1'b1;
                    alloc_idx_s = free_idx_r;
                end else begin
`ifdef VOICE_STEAL_EN
                    alloc_s     = 1'b1;
                    alloc_idx_s = old_idx_r;
`else
                    drop_s      = 1'b1;
`endif
                end
            end else begin
                if (match_found_r) begin
                    release_s     = 1'b1;
                    release_idx_s = match_idx_r;
                end else begin
                    release_s     = 1'b0;
                end
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Voice table: the only place outputs change outside of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_VOICES; i++) begin
                note_r[i] <= {NOTE_W{1'b0}};
                age_r[i]  <= 8'd0;
                freq_r[i] <= {FREQ_W{1'b0}};
                vol_r[i]  <= 32'd0;
            end
            active_r <= {N_VOICES{1'b0}};
        end else begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (alloc_s && (alloc_idx_s == IDX_W'(i))) begin
                    note_r[i]   <= ev_note_r;
                    age_r[i]    <= 8'd0;
                    freq_r[i]   <= ev_freq_r;
                    vol_r[i]    <= vol_of(ev_vel_r);
                    active_r[i] <= 1'b1;
                end else if (alloc_s && active_r[i]) begin
                    age_r[i] <= age_inc(age_r[i]);
                end else if (release_s && (release_idx_s == IDX_W'(i))) begin
                    vol_r[i]    <= 32'd0;
                    active_r[i] <= 1'b0;
                    age_r[i]    <= 8'd0;
                end
            end
        end
    end

    assign note_ready    = ready_r;
    assign note_dropped  = dropped_r;
    assign voice_active  = active_r;
    assign frequencies   = freq_r;
    assign voice_volumes = vol_r;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Directed stimulus with a scoreboard. Each accepted event pushes its
// hand-computed expected voice table. A monitor pops that table when
// note_ready rises, which marks the end of an apply cycle or of a reset.
module tb_voice_allocator;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        note_valid = 1'b0;
    logic        note_on = 1'b0;
    logic [6:0]  note_num = 7'd0;
    logic [6:0]  note_velocity = 7'd0;
    logic [31:0] note_frequency = 32'd0;
    logic        note_ready;
    logic [31:0] frequencies   [N];
    logic [31:0] voice_volumes [N];
    logic [N-1:0] voice_active;
    logic        note_dropped;

    always #5 clk = ~clk;

    voice_allocator #(
        .N_VOICES (8),
        .NOTE_W   (7),
        .FREQ_W   (32),
        .VOL_SHIFT(9)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .note_valid    (note_valid),
        .note_ready    (note_ready),
        .note_on       (note_on),
        .note_num      (note_num),
        .note_velocity (note_velocity),
        .note_frequency(note_frequency),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .voice_active  (voice_active),
        .note_dropped  (note_dropped)
    );

    typedef struct {
        logic [N-1:0][31:0] freq;
        logic [N-1:0][31:0] vol;
        logic [N-1:0]       act;
        logic               drop;
        int                 hs;
        bit                 chk_lat;
        int                 id;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   ev_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    function automatic logic [255:0] pack_freq();
        logic [N-1:0][31:0] f;
        for (int i = 0; i < N; i++) f[i] = frequencies[i];
        return f;
    endfunction

    function automatic logic [255:0] pack_vol();
        logic [N-1:0][31:0] v;
        for (int i = 0; i < N; i++) v[i] = voice_volumes[i];
        return v;
    endfunction

    // Expected-table edits, applied by hand at each step.
    task automatic m_reset();
        cur.freq = '0;
        cur.vol  = '0;
        cur.act  = '0;
        cur.drop = 1'b0;
    endtask

    task automatic m_on(input int slot, input logic [31:0] f, input logic [31:0] v);
        cur.freq[slot] = f;
        cur.vol[slot]  = v;
        cur.act[slot]  = 1'b1;
    endtask

    task automatic m_off(input int slot);
        cur.vol[slot] = 32'd0;
        cur.act[slot] = 1'b0;
    endtask

    task automatic push(input logic drop, input bit lat);
        exp_t e;
        e = cur;
        e.drop = drop;
        e.hs = hs_cyc;
        e.chk_lat = lat;
        e.id = ev_id;
        ev_id++;
        q.push_back(e);
    endtask

    // Drive one event and return just after the handshake edge.
    task automatic send(input bit on, input int num, input int vel, input int freq, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        note_on = on;
        note_num = 7'(num);
        note_velocity = 7'(vel);
        note_frequency = 32'(freq);
        note_valid = 1'b1;
        while (note_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait", {255'd0, note_ready}, 256'd1);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (!keep) note_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 256'(q.size()), 256'd0);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        note_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        m_reset();
        push(1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    // Monitor: compare on each rising note_ready; otherwise note_dropped must stay low.
    initial begin : monitor
        logic prev_ready;
        exp_t e;
        prev_ready = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (note_ready === 1'b1 && prev_ready !== 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_completion", 256'd1, 256'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("ev%0d_freq", e.id), pack_freq(), e.freq);
                    check($sformatf("ev%0d_vol", e.id), pack_vol(), e.vol);
                    check($sformatf("ev%0d_active", e.id), {248'd0, voice_active}, {248'd0, e.act});
                    check($sformatf("ev%0d_dropped", e.id), {255'd0, note_dropped}, {255'd0, e.drop});
                    if (e.chk_lat) begin
                        check($sformatf("ev%0d_latency", e.id), 256'(cyc - e.hs), 256'(N + 1));
                    end
                end
            end else begin
                check("dropped_idle", {255'd0, note_dropped}, 256'd0);
            end
            prev_ready = note_ready;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int prev_hs;

        // Single note-on after a three-cycle reset.
        do_reset(3);
        wait_done();
        send(1'b1, 60, 100, 450560, 1'b0);
        m_on(0, 32'd450560, 32'd51200);
        push(1'b0, 1'b1);
        wait_done();

        // Back-to-back note-ons, release, refill of the freed slot.
        do_reset(2);
        wait_done();
        send(1'b1, 60, 64, 60000, 1'b0); m_on(0, 32'd60000, 32'd32768); push(1'b0, 1'b1);
        send(1'b1, 62, 64, 62000, 1'b0); m_on(1, 32'd62000, 32'd32768); push(1'b0, 1'b1);
        send(1'b1, 64, 64, 64000, 1'b0); m_on(2, 32'd64000, 32'd32768); push(1'b0, 1'b1);
        send(1'b0, 62, 0, 0, 1'b0);      m_off(1);                        push(1'b0, 1'b1);
        send(1'b1, 67, 64, 67000, 1'b0); m_on(1, 32'd67000, 32'd32768); push(1'b0, 1'b1);
        wait_done();

        // Retrigger, zero-velocity note-on as release, unmatched note-off.
        do_reset(2);
        wait_done();
        send(1'b1, 60, 100, 450560, 1'b0); m_on(0, 32'd450560, 32'd51200); push(1'b0, 1'b1);
        send(1'b1, 60, 20, 450560, 1'b0);  m_on(0, 32'd450560, 32'd10240); push(1'b0, 1'b1);
        send(1'b1, 60, 0, 123, 1'b0);      m_off(0);                         push(1'b0, 1'b1);
        send(1'b0, 99, 0, 0, 1'b0);                                          push(1'b0, 1'b1);
        wait_done();

        // Fill every slot, then one more note-on.
        do_reset(2);
        wait_done();
        for (int i = 0; i < N; i++) begin
            send(1'b1, 60 + i, 64, (60 + i) * 1000, 1'b0);
            m_on(i, 32'((60 + i) * 1000), 32'd32768);
            push(1'b0, 1'b1);
        end
        send(1'b1, 68, 64, 68000, 1'b0);
`ifdef VOICE_STEAL_EN
        m_on(0, 32'd68000, 32'd32768);
        push(1'b0, 1'b1);
`else
        push(1'b1, 1'b1);
        send(1'b0, 60, 0, 0, 1'b0);
        m_off(0);
        push(1'b0, 1'b1);
`endif
        wait_done();

        // Reset while an event is being scanned: event lost, outputs cleared.
        send(1'b1, 90, 64, 90000, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_active", {248'd0, voice_active}, 256'd0);
        check("abort_freq", pack_freq(), 256'd0);
        check("abort_vol", pack_vol(), 256'd0);
        check("abort_ready", {255'd0, note_ready}, 256'd0);
        repeat (2) @(negedge clk);
        m_reset();
        push(1'b0, 1'b0);
        reset_n = 1'b1;
        wait_done();

        // note_valid held high across alternating events.
        send(1'b1, 70, 64, 70000, 1'b1); m_on(0, 32'd70000, 32'd32768); push(1'b0, 1'b1);
        prev_hs = hs_cyc;
        send(1'b0, 70, 0, 0, 1'b1);      m_off(0);                        push(1'b0, 1'b1);
        check("accept_period_1", 256'(hs_cyc - prev_hs), 256'(N + 2));
        prev_hs = hs_cyc;
        send(1'b1, 71, 64, 71000, 1'b1); m_on(0, 32'd71000, 32'd32768); push(1'b0, 1'b1);
        check("accept_period_2", 256'(hs_cyc - prev_hs), 256'(N + 2));
        prev_hs = hs_cyc;
        send(1'b0, 71, 0, 0, 1'b0);      m_off(0);                        push(1'b0, 1'b1);
        check("accept_period_3", 256'(hs_cyc - prev_hs), 256'(N + 2));
        wait_done();
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
